paddle_ctrl: RTL and testbench
==============================

PADDLE_CTRL -- requirements
Module: paddle_ctrl

Interface
REQ-001 Parameters: PADDLE_H 72 paddle height px; TOP_MARGIN 25 score-bar height px; SCREEN_H 480 visible lines; PADDLE_SPEED 4 px per refresh_tick; AI_SPEED 2 px per refresh_tick; DEAD_ZONE 4 px AI tolerance; BALL_SIZE 8 ball edge px; DEB_CYCLES 500000 debounce clocks.
REQ-002 Derived constant PADDLE_MAX = SCREEN_H - TOP_MARGIN - PADDLE_H (383 at defaults); PADDLE_RST = PADDLE_MAX >> 1 (191).
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 refresh_tick  input  1  one-clk pulse per frame; all paddle motion occurs only on it.
REQ-006 btn_up1, btn_dn1  input  1 each  raw asynchronous player-1 buttons, active-high.
REQ-007 btn_up2, btn_dn2  input  1 each  raw asynchronous player-2 buttons, active-high.
REQ-008 ai_en  input  1  level; 1 = paddle 2 computer-driven, 0 = buttons.
REQ-009 ball_y  input  10  ball top-edge screen row from the ball block.
REQ-010 paddle1_y, paddle2_y  output  10 each  registered paddle top offset below TOP_MARGIN, range 0..PADDLE_MAX.
REQ-011 btn_db  output  4  registered debounced levels {dn2, up2, dn1, up1}.

Function
REQ-012 Each raw button passes a 2-flop synchronizer before any other logic.
REQ-013 Per button, one debounce counter: clears when synchronized level equals debounced level; otherwise increments; when it reaches DEB_CYCLES-1 the debounced level toggles and counter clears same cycle.
REQ-014 Debounced level thus changes exactly DEB_CYCLES clocks after a stable synchronized change; any glitch shorter than DEB_CYCLES leaves it unchanged.
REQ-015 Paddle 1 on refresh_tick: up only -> y - PADDLE_SPEED; down only -> y + PADDLE_SPEED; both or neither -> hold.
REQ-016 Up clamp: if y < PADDLE_SPEED, result 0 (no unsigned wrap).
REQ-017 Down clamp: if y + PADDLE_SPEED > PADDLE_MAX, result PADDLE_MAX; sum computed in 11 bits.
REQ-018 Paddle 2 with ai_en=0: identical rules to REQ-015..017 using up2/dn2.
REQ-019 Paddle 2 with ai_en=1: buttons ignored; compute signed 12-bit err = (ball_y + BALL_SIZE/2) - (paddle2_y + TOP_MARGIN + PADDLE_H/2).
REQ-020 AI step on refresh_tick: err > DEAD_ZONE -> move down AI_SPEED; err < -DEAD_ZONE -> move up AI_SPEED; else hold; same clamps as REQ-016/017 with AI_SPEED.
REQ-021 err is computed from ball_y sampled on the same clock as refresh_tick; one-tick latency from ball_y to paddle move.
REQ-022 ai_en change takes effect at next refresh_tick; no position jump on change.
REQ-023 Outputs hold between ticks; position update visible one clk after refresh_tick.
REQ-024 paddle1_y and paddle2_y never exceed PADDLE_MAX under any input sequence.

Reset
REQ-025 reset asserted: paddle1_y = paddle2_y = PADDLE_RST, btn_db = 0, debounce counters and synchronizers = 0, immediately without clk.
REQ-026 reset asserted mid-debounce or mid-move abandons the operation; after release, first motion requires fresh DEB_CYCLES-stable press.
REQ-027 refresh_tick during reset ignored.

Verification (DEB_CYCLES overridden to 8 in bench)
REQ-028 Reset pulse -> paddle1_y = paddle2_y = 191, btn_db = 0000 before any clk edge.
REQ-029 btn_up1 held 3 clks then released -> btn_db[0] stays 0; held 12 clks -> btn_db[0] rises 8 clks after synchronizer output rises (10 after pin).
REQ-030 Paddle 1 at 2, up held, tick -> 0; further ticks -> 0; paddle 1 at 381, down held, tick -> 383, stays 383.
REQ-031 up1 and dn1 both debounced high, 5 ticks -> paddle1_y unchanged at 191.
REQ-032 ai_en=1, paddle2_y=191 (centre row 252), ball_y=300 (centre 304, err 52) -> +2 per tick; ball_y=246 (centre 250, err -2) -> hold; btn_up2 held has no effect.
REQ-033 ai_en=1, ball_y=470, 200 ticks -> paddle2_y saturates at 383, never exceeds.

Source files
------------

// File: rtl/paddle_if.sv
// Pong paddle controller bus: frame tick, buttons,
// AI controls in; paddle positions and debounced buttons out.
interface paddle_if;
  logic       refresh_tick;
  logic       btn_up1;
  logic       btn_dn1;
  logic       btn_up2;
  logic       btn_dn2;
  logic       ai_en;
  logic [9:0] ball_y;
  logic [9:0] paddle1_y;
  logic [9:0] paddle2_y;
  logic [3:0] btn_db;

  modport master (
    output refresh_tick, btn_up1, btn_dn1,
    output btn_up2, btn_dn2, ai_en, ball_y,
    input  paddle1_y, paddle2_y, btn_db
  );

  modport slave (
    input  refresh_tick, btn_up1, btn_dn1,
    input  btn_up2, btn_dn2, ai_en, ball_y,
    output paddle1_y, paddle2_y, btn_db
  );
endinterface

// File: rtl/paddle_ctrl.sv
// Two-player pong paddle controller: synchronized, debounced
// buttons drive paddle 1; paddle 2 from buttons or ball-tracking AI.
module paddle_ctrl #(
  parameter int PADDLE_H     = 72,
  parameter int TOP_MARGIN   = 25,
  parameter int SCREEN_H     = 480,
  parameter int PADDLE_SPEED = 4,
  parameter int AI_SPEED     = 2,
  parameter int DEAD_ZONE    = 4,
  parameter int BALL_SIZE    = 8,
  parameter int DEB_CYCLES   = 500000
) (
  input  logic     clk,
  input  logic     reset,
  paddle_if.slave  pif
);

  localparam int CW =
    (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(DEB_CYCLES - 1);

  localparam logic [9:0] PMAX =
    10'(SCREEN_H - TOP_MARGIN - PADDLE_H);
  localparam logic [9:0] PRST = PMAX >> 1;
  localparam logic [9:0] SPD  = 10'(PADDLE_SPEED);
  localparam logic [9:0] ASPD = 10'(AI_SPEED);

  localparam logic signed [11:0] DZ_P = 12'(DEAD_ZONE);
  localparam logic signed [11:0] DZ_N = -DZ_P;
  localparam logic [11:0] BALL_C = 12'(BALL_SIZE / 2);
  localparam logic [11:0] PAD_C  =
    12'(TOP_MARGIN + PADDLE_H / 2);

  logic [3:0]    raw;
  logic [3:0]    s1;
  logic [3:0]    s2;
  logic [3:0]    db;
  logic [CW-1:0] cnt [4];

  assign raw = {pif.btn_dn2, pif.btn_up2,
                pif.btn_dn1, pif.btn_up1};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      db <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int i = 0; i < 4; i++) begin
        if (s2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_TOP) begin
          cnt[i] <= '0;
          db[i]  <= ~db[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Saturating move; sum kept 11 bits so the top clamp never wraps.
  function automatic logic [9:0] step(
    input logic [9:0] y,
    input logic       up,
    input logic       dn,
    input logic [9:0] spd
  );
    logic [10:0] sum;
    sum  = {1'b0, y} + {1'b0, spd};
    step = y;
    if (up && !dn)
      step = (y < spd) ? '0 : y - spd;
    else if (dn && !up)
      step = (sum > {1'b0, PMAX}) ? PMAX : sum[9:0];
  endfunction

  logic [9:0]        p1;
  logic [9:0]        p2;
  logic [9:0]        p1_nx;
  logic [9:0]        p2_nx;
  logic signed [11:0] err;
  logic              ai_up;
  logic              ai_dn;

  always_comb begin
    err   = '0;
    ai_up = 1'b0;
    ai_dn = 1'b0;
    err   = 12'(pif.ball_y) + BALL_C - 12'(p2) - PAD_C;
    ai_dn = (err > DZ_P);
    ai_up = (err < DZ_N);
  end

  always_comb begin
    p1_nx = step(p1, db[0], db[1], SPD);
    p2_nx = pif.ai_en ? step(p2, ai_up, ai_dn, ASPD)
                      : step(p2, db[2], db[3], SPD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p1 <= PRST;
      p2 <= PRST;
    end else if (pif.refresh_tick) begin
      p1 <= p1_nx;
      p2 <= p2_nx;
    end
  end

  assign pif.paddle1_y = p1;
  assign pif.paddle2_y = p2;
  assign pif.btn_db    = db;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Self-checking bench for paddle_ctrl: vector table, corner
// sequences and randomized runs against an integer model.
module tb_paddle_ctrl;

  localparam int DEB  = 8;
  localparam int PMAX = 480 - 25 - 72;
  localparam int PRST = PMAX / 2;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   m1;
  int   m2;

  paddle_if pif();

  paddle_ctrl #(.DEB_CYCLES(DEB)) dut (
    .clk   (clk),
    .reset (reset),
    .pif   (pif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] btn;
    logic       ai;
    logic [9:0] ball;
    int         nt;
    int         e1;
    int         e2;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", n, a, e);
    end
  endtask

  function automatic int clampy(input int y);
    if (y < 0) return 0;
    if (y > PMAX) return PMAX;
    return y;
  endfunction

  function automatic int bdir(input logic up, input logic dn);
    if (up && !dn) return -1;
    if (dn && !up) return 1;
    return 0;
  endfunction

  task automatic mtick();
    int e;
    m1 = clampy(m1 + 4 * bdir(pif.btn_up1, pif.btn_dn1));
    if (pif.ai_en) begin
      e = (int'(pif.ball_y) + 4) - (m2 + 25 + 36);
      if (e > 4) m2 = clampy(m2 + 2);
      else if (e < -4) m2 = clampy(m2 - 2);
    end else begin
      m2 = clampy(m2 + 4 * bdir(pif.btn_up2, pif.btn_dn2));
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      @(negedge clk);
      pif.refresh_tick = 1'b1;
      mtick();
      @(negedge clk);
      pif.refresh_tick = 1'b0;
    end
  endtask

  task automatic set_btn(input logic [3:0] b);
    @(negedge clk);
    {pif.btn_dn2, pif.btn_up2, pif.btn_dn1, pif.btn_up1} = b;
    repeat (DEB + 4) @(negedge clk);
  endtask

  initial begin
    int  mx;
    logic bad;
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    pif.refresh_tick = 1'b0;
    pif.btn_up1 = 1'b0;
    pif.btn_dn1 = 1'b0;
    pif.btn_up2 = 1'b0;
    pif.btn_dn2 = 1'b0;
    pif.ai_en   = 1'b0;
    pif.ball_y  = '0;
    m1 = PRST;
    m2 = PRST;

    vecs[0]  = '{4'b0000, 1'b0, 10'd0,   3,  191, 191};
    vecs[1]  = '{4'b0001, 1'b0, 10'd0,   47, 3,   191};
    vecs[2]  = '{4'b0001, 1'b0, 10'd0,   1,  0,   191};
    vecs[3]  = '{4'b0001, 1'b0, 10'd0,   3,  0,   191};
    vecs[4]  = '{4'b0010, 1'b0, 10'd0,   95, 380, 191};
    vecs[5]  = '{4'b0010, 1'b0, 10'd0,   1,  383, 191};
    vecs[6]  = '{4'b0010, 1'b0, 10'd0,   3,  383, 191};
    vecs[7]  = '{4'b0001, 1'b0, 10'd0,   48, 191, 191};
    vecs[8]  = '{4'b0011, 1'b0, 10'd0,   5,  191, 191};
    vecs[9]  = '{4'b0100, 1'b1, 10'd246, 4,  191, 191};
    vecs[10] = '{4'b0100, 1'b1, 10'd300, 1,  191, 193};
    vecs[11] = '{4'b0100, 1'b1, 10'd300, 3,  191, 199};
    vecs[12] = '{4'b0100, 1'b0, 10'd300, 2,  191, 191};
    vecs[13] = '{4'b1000, 1'b0, 10'd300, 1,  191, 195};
    vecs[14] = '{4'b0000, 1'b1, 10'd0,   98, 191, 0};

    #1;
    chk("rst_p1", int'(pif.paddle1_y), PRST);
    chk("rst_p2", int'(pif.paddle2_y), PRST);
    chk("rst_db", int'(pif.btn_db), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // short glitch must not reach the debounced level
    @(negedge clk);
    pif.btn_up1 = 1'b1;
    repeat (3) @(negedge clk);
    pif.btn_up1 = 1'b0;
    bad = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (pif.btn_db[0]) bad = 1'b1;
    end
    chk("glitch_db0", int'(bad), 0);

    @(negedge clk);
    pif.btn_up1 = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("deb_edge%0d", k),
          int'(pif.btn_db[0]), (k >= 10) ? 1 : 0);
    end
    @(negedge clk);
    pif.btn_up1 = 1'b0;
    repeat (DEB + 4) @(negedge clk);
    chk("deb_release", int'(pif.btn_db), 0);

    for (int i = 0; i < 15; i++) begin
      pif.ai_en  = vecs[i].ai;
      pif.ball_y = vecs[i].ball;
      set_btn(vecs[i].btn);
      chk($sformatf("vec%0d_db", i),
          int'(pif.btn_db), int'(vecs[i].btn));
      ticks(vecs[i].nt);
      chk($sformatf("vec%0d_p1", i),
          int'(pif.paddle1_y), vecs[i].e1);
      chk($sformatf("vec%0d_p2", i),
          int'(pif.paddle2_y), vecs[i].e2);
    end

    // AI chasing a ball at the bottom must saturate, never overshoot
    pif.ai_en  = 1'b1;
    pif.ball_y = 10'd470;
    mx = 0;
    for (int t = 0; t < 200; t++) begin
      ticks(1);
      if (int'(pif.paddle2_y) > mx) mx = int'(pif.paddle2_y);
    end
    chk("ai_sat_max", mx, PMAX);
    chk("ai_sat_final", int'(pif.paddle2_y), PMAX);
    chk("ai_sat_model", int'(pif.paddle2_y), m2);

    // reset mid-move abandons everything, ticks during reset ignored
    pif.ai_en = 1'b0;
    set_btn(4'b0010);
    ticks(2);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_p1", int'(pif.paddle1_y), PRST);
    chk("mid_rst_p2", int'(pif.paddle2_y), PRST);
    chk("mid_rst_db", int'(pif.btn_db), 0);
    @(negedge clk);
    pif.refresh_tick = 1'b1;
    @(negedge clk);
    pif.refresh_tick = 1'b0;
    chk("rst_tick_p1", int'(pif.paddle1_y), PRST);
    reset = 1'b0;
    m1 = PRST;
    m2 = PRST;
    repeat (5) @(negedge clk);
    chk("post_rst_db_early", int'(pif.btn_db), 0);
    repeat (7) @(negedge clk);
    chk("post_rst_db_late", int'(pif.btn_db), 2);

    for (int r = 0; r < 40; r++) begin
      logic [3:0] b;
      b = 4'($urandom_range(0, 15));
      pif.ai_en  = 1'($urandom_range(0, 1));
      pif.ball_y = 10'($urandom_range(0, 479));
      set_btn(b);
      chk($sformatf("rnd%0d_db", r), int'(pif.btn_db), int'(b));
      ticks($urandom_range(1, 20));
      chk($sformatf("rnd%0d_p1", r), int'(pif.paddle1_y), m1);
      chk($sformatf("rnd%0d_p2", r), int'(pif.paddle2_y), m2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
